plru_sync_sink32: RTL



---
 rtl/plru_sync_sink32.sv | 107 ++++++++++
 1 files changed

// File: rtl/plru_sync_sink32.sv
// plru_sync_sink32: clocked sink for a 2-phase bundled-data merge; encodes the one-hot
// grant, updates a 32-way tree pseudo-LRU and returns a 2-phase free toggle.
module plru_sync_sink32 #(
    parameter int WAYS        = 32,
    parameter int IDX_W       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_drive,
    input  logic [WAYS-1:0]     i_data,
    input  logic                i_flush,
    input  logic                i_err_clr,
    output logic                o_free,
    output logic [IDX_W-1:0]    o_way,
    output logic                o_way_valid,
    output logic [IDX_W-1:0]    o_victim,
    output logic [WAYS-2:0]     o_plru,
    output logic                o_err
);
    typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, UPDATE, ACK} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   d_prev, d_sync, evt, one_hot;
    logic [WAYS-1:0]        grant_q;
    logic [IDX_W-1:0]       idx_q, idx_c, victim_c;
    logic [WAYS-2:0]        tree_upd;

    assign d_sync  = sync[SYNC_STAGES-1];
    assign evt     = d_sync ^ d_prev;
    assign one_hot = (grant_q != '0) && ((grant_q & (grant_q - 1'b1)) == '0);

    always_comb begin
        idx_c = '0;
        for (int w = 0; w < WAYS; w++)
            if (grant_q[w]) idx_c = IDX_W'(w);
    end

    // Walk root to leaf along idx_q, pointing every visited node away from it.
    always_comb begin
        logic [IDX_W-1:0] n;
        logic             b;
        tree_upd = o_plru;
        n        = '0;
        for (int l = 0; l < IDX_W; l++) begin
            b           = idx_q[IDX_W-1-l];
            tree_upd[n] = ~b;
            n           = {n[IDX_W-2:0], 1'b0} + 1'b1 + {{(IDX_W-1){1'b0}}, b};
        end
    end

    always_comb begin
        logic [IDX_W-1:0] m;
        logic             b;
        victim_c = '0;
        m        = '0;
        for (int l = 0; l < IDX_W; l++) begin
            b                   = o_plru[m];
            victim_c[IDX_W-1-l] = b;
            m                   = {m[IDX_W-2:0], 1'b0} + 1'b1 + {{(IDX_W-1){1'b0}}, b};
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = evt ? CAPTURE : IDLE;
            CAPTURE: state_n = CHECK;
            CHECK:   state_n = one_hot ? UPDATE : ACK;
            UPDATE:  state_n = ACK;
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync        <= '0;
            d_prev      <= 1'b0;
            state       <= IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            o_free      <= 1'b0;
            o_way       <= '0;
            o_way_valid <= 1'b0;
            o_plru      <= '0;
            o_victim    <= '0;
            o_err       <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], i_drive};
            d_prev      <= d_sync;
            state       <= state_n;
            o_way_valid <= state == UPDATE;
            o_victim    <= victim_c;
            if (state == CAPTURE) grant_q <= i_data;
            if (state == CHECK) idx_q <= idx_c;
            if (state == UPDATE) o_way <= idx_q;
            if (state == ACK) o_free <= ~o_free;
            // Flush beats a coincident update; the rest of the handshake still runs.
            if (i_flush) o_plru <= '0;
            else if (state == UPDATE) o_plru <= tree_upd;
            if ((state == CHECK && !one_hot) || (evt && state != IDLE)) o_err <= 1'b1;
            else if (i_err_clr) o_err <= 1'b0;
        end
    end
endmodule
